lfsr_run_ctrl: RTL

//   Sequencer for the LFSR pattern-detector datapath (16-bit LFSR, 8-bit match counter, max_tick on wrap).

---
 rtl/lfsr_run_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/lfsr_run_ctrl.sv
// Run sequencer for the LFSR pattern-detector datapath: seeds, clears, steps and captures one run.
// Optional abort input is enabled by defining LFSR_RUN_ABORT_EN.
module lfsr_run_ctrl #(
  parameter int LFSR_W = 16,
  parameter int CNT_W  = 8,
  parameter int STEP_W = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic [STEP_W-1:0] step_limit_i,
  input  logic              max_tick_i,
  input  logic [CNT_W-1:0]  det_count_i,
`ifdef LFSR_RUN_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              lfsr_load_o,
  output logic [LFSR_W-1:0] lfsr_seed_o,
  output logic              lfsr_en_o,
  output logic              det_clr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wrapped_o,
  output logic [CNT_W-1:0]  result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic [STEP_W-1:0] limit_q, limit_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              cause_q, cause_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              wrapped_q, wrapped_d;

  logic              limitHit;
  logic              abortReq;

  assign limitHit = (limit_q != '0) && (step_q == (limit_q - STEP_W'(1)));

`ifdef LFSR_RUN_ABORT_EN
  assign abortReq = abort_i;
`else
  assign abortReq = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
      cause_q   <= 1'b0;
      result_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
      cause_q   <= cause_d;
      result_q  <= result_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    limit_d   = limit_q;
    step_d    = step_q;
    cause_d   = cause_q;
    result_d  = result_q;
    wrapped_d = wrapped_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          // An all-zero seed would lock the LFSR, so substitute 1.
          seed_d  = (seed_i == '0) ? LFSR_W'(1) : seed_i;
          limit_d = step_limit_i;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        step_d  = '0;
        cause_d = 1'b0;
        state_d = abortReq ? S_CAPTURE : S_RUN;
      end
      S_RUN: begin
        if (step_q != '1) begin
          step_d = step_q + STEP_W'(1);
        end
        if (max_tick_i || limitHit || abortReq) begin
          cause_d = max_tick_i;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        result_d  = det_count_i;
        wrapped_d = cause_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign lfsr_load_o = (state_q == S_LOAD);
  assign det_clr_o   = (state_q == S_LOAD);
  assign lfsr_en_o   = (state_q == S_RUN);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign lfsr_seed_o = seed_q;
  assign wrapped_o   = wrapped_q;
  assign result_o    = result_q;

endmodule
